// File: rtl/svc_rv_muldiv.sv
// RV32M/Zmmul execute unit: multi-cycle multiplier plus an optional restoring divider.
// Define SVC_RV_MULDIV_DIV_EN to build DIV/DIVU/REM/REMU; without it those ops return out_illegal=1.

module svc_rv_muldiv #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_illegal
);
    localparam int CW = $clog2(XLEN);

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
    // waits on ready, and the payload stays stable while valid && !ready.
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic              accept;
    logic              a_sgn, b_sgn;
    logic              mul_hi_q;
    logic [XLEN:0]     mul_a, mul_b;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res;

    assign accept = in_valid && in_ready && !flush;
    assign a_sgn  = (in_op[1:0] == 2'b01) || (in_op[1:0] == 2'b10);
    assign b_sgn  = (in_op[1:0] == 2'b01);

    // Operands carry one extension bit; widening to 2*XLEN keeps the low product bits exact.
    assign prod    = {{(XLEN-1){mul_a[XLEN]}}, mul_a} * {{(XLEN-1){mul_b[XLEN]}}, mul_b};
    assign mul_res = mul_hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];

`ifdef SVC_RV_MULDIV_DIV_EN
    logic [XLEN-1:0] quo, rem, dvs;
    logic            q_neg, r_neg, rem_sel;
    logic            div_signed, a_neg, b_neg, div_zero, div_ovf, special;
    logic [XLEN-1:0] a_mag, b_mag, special_res, quo_fix, rem_fix;
    logic [XLEN:0]   r_sh, diff;

    always_comb begin
        div_signed  = !in_op[0];
        a_neg       = div_signed && in_rs1[XLEN-1];
        b_neg       = div_signed && in_rs2[XLEN-1];
        a_mag       = a_neg ? -in_rs1 : in_rs1;
        b_mag       = b_neg ? -in_rs2 : in_rs2;
        div_zero    = (in_rs2 == '0);
        div_ovf     = div_signed && (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&in_rs2);
        special     = div_zero || div_ovf;
        special_res = div_zero ? (in_op[1] ? in_rs1 : '1) : (in_op[1] ? '0 : in_rs1);
        // diff[XLEN] set means the shifted remainder is below the divisor (borrow).
        r_sh        = {rem, quo[XLEN-1]};
        diff        = r_sh - {1'b0, dvs};
        quo_fix     = q_neg ? -quo : quo;
        rem_fix     = r_neg ? -rem : rem;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (in_valid) begin
`ifdef SVC_RV_MULDIV_DIV_EN
                state_nxt = !in_op[2] ? S_MUL : (special ? S_DONE : S_DIV);
`else
                state_nxt = !in_op[2] ? S_MUL : S_DONE;
`endif
            end
            S_MUL:  if (cnt == '0) state_nxt = S_DONE;
`ifdef SVC_RV_MULDIV_DIV_EN
            S_DIV:  if (cnt == '0) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_DONE;
`endif
            S_DONE: if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            mul_hi_q    <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            out_result  <= '0;
            out_illegal <= 1'b0;
`ifdef SVC_RV_MULDIV_DIV_EN
            quo         <= '0;
            rem         <= '0;
            dvs         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            rem_sel     <= 1'b0;
`endif
        end else if (accept) begin
            mul_hi_q    <= (in_op[1:0] != 2'b00);
            mul_a       <= {a_sgn & in_rs1[XLEN-1], in_rs1};
            mul_b       <= {b_sgn & in_rs2[XLEN-1], in_rs2};
            out_illegal <= 1'b0;
            if (!in_op[2]) begin
                cnt <= CW'(MUL_STAGES - 1);
            end else begin
`ifdef SVC_RV_MULDIV_DIV_EN
                rem_sel <= in_op[1];
                if (special) begin
                    out_result <= special_res;
                end else begin
                    quo   <= a_mag;
                    rem   <= '0;
                    dvs   <= b_mag;
                    q_neg <= a_neg ^ b_neg;
                    r_neg <= a_neg;
                    cnt   <= CW'(XLEN - 1);
                end
`else
                out_result  <= '0;
                out_illegal <= 1'b1;
`endif
            end
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case (state)
                S_MUL: begin
                    if (cnt == '0) out_result <= mul_res;
                    else           cnt <= cnt - CW'(1);
                end
`ifdef SVC_RV_MULDIV_DIV_EN
                S_DIV: begin
                    rem <= diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
                    quo <= {quo[XLEN-2:0], ~diff[XLEN]};
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
                S_FIX: out_result <= rem_sel ? rem_fix : quo_fix;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_svc_rv_muldiv.sv
// Scoreboard bench for svc_rv_muldiv: directed test-plan cases, flush/reset cases, random ops.
// Expected results follow SVC_RV_MULDIV_DIV_EN the same way the design does.

module tb_svc_rv_muldiv;
    localparam int XLEN       = 32;
    localparam int MUL_STAGES = 2;
`ifdef SVC_RV_MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam logic [XLEN-1:0] MIN_INT = 32'h8000_0000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      in_op = 3'd0;
    logic [XLEN-1:0] in_rs1 = '0;
    logic [XLEN-1:0] in_rs2 = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] out_result;
    logic            out_illegal;

    svc_rv_muldiv #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_illegal(out_illegal)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout actual=cycle %0d required=finish earlier", cyc);
        $fatal(1, "global timeout");
    end

    // ---------------- scoreboard state ----------------
    logic [XLEN:0] exp_q[$];
    int            lat_q[$];
    int            acc_q[$];
    bit            seen = 1'b0;
    int            checks = 0;
    int            failures = 0;
    int            stall_cycles = 0;
    bit            rand_bp = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [XLEN:0] model(input logic [2:0] op, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
        longint sa, sb, ua, ub, p;
        logic [XLEN-1:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        r  = '0;
        p  = 0;
        if (op[2] && !DIV_EN) return {1'b1, {XLEN{1'b0}}};
        case (op)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = '1;
                else if (a == MIN_INT && b == '1) r = a;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == MIN_INT && b == '1) r = '0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return {1'b0, r};
    endfunction

    function automatic int latency(input logic [2:0] op, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
        if (!op[2]) return MUL_STAGES + 1;
        if (!DIV_EN) return 1;
        if (b == 0 || (!op[0] && a == MIN_INT && b == '1)) return 1;
        return XLEN + 2;
    endfunction

    // ---------------- consumer backpressure ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_cycles > 0) begin
                out_ready = 1'b0;
                stall_cycles--;
            end else begin
                out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else if (exp_q.size() == 0) begin
            check("no_unexpected_valid", {63'd0, out_valid}, 64'd0);
        end else if (out_valid) begin
            if (!seen) begin
                check("latency", 64'(cyc - acc_q[0] + 1), 64'(lat_q[0]));
                seen = 1'b1;
            end
            check("result", {31'd0, out_illegal, out_result}, {31'd0, exp_q[0]});
            check("in_ready_busy", {63'd0, in_ready}, 64'd0);
            if (out_ready) begin
                void'(exp_q.pop_front());
                void'(lat_q.pop_front());
                void'(acc_q.pop_front());
                seen = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN:0] exp, input int lat, input bit expect_it);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
            return;
        end
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        @(posedge clk);
        #1;
        if (expect_it) begin
            exp_q.push_back(exp);
            lat_q.push_back(lat);
            acc_q.push_back(cyc);
        end
        in_valid = 1'b0;
        in_op    = 3'($urandom_range(0, 7));
        in_rs1   = $urandom;
        in_rs2   = $urandom;
    endtask

    task automatic issue_div(input logic [2:0] op, input logic [XLEN-1:0] a,
                             input logic [XLEN-1:0] b, input logic [XLEN-1:0] val, input int lat);
        issue(op, a, b, DIV_EN ? {1'b0, val} : {1'b1, {XLEN{1'b0}}}, DIV_EN ? lat : 1, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic flush_op(input logic [2:0] op, input logic [XLEN-1:0] a,
                            input logic [XLEN-1:0] b, input int k);
        issue(op, a, b, '0, 0, 1'b0);
        repeat (k - 1) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    endtask

    function automatic logic [XLEN-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return MIN_INT;
            3: return 32'd1;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0]      op;
        logic [XLEN-1:0] a, b;

        repeat (3) @(negedge clk);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_out_result", 64'(out_result), 64'd0);
        check("reset_out_illegal", {63'd0, out_illegal}, 64'd0);
        #2 rst_n = 1'b1;

        issue(3'b001, 32'hFFFF_FFFF, 32'd2, {1'b0, 32'hFFFF_FFFF}, 3, 1'b1);
        issue(3'b011, 32'hFFFF_FFFF, 32'd2, {1'b0, 32'h0000_0001}, 3, 1'b1);
        issue(3'b000, 32'd7, 32'd6, {1'b0, 32'h0000_002A}, 3, 1'b1);
        issue(3'b000, 32'd10, 32'd2, {1'b0, 32'd20}, 3, 1'b1);
        drain();

        stall_cycles = 12;
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'h8000_0000}, 3, 1'b1);
        drain();

        issue_div(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        issue_div(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        issue_div(3'b101, 32'd100, 32'd7, 32'd14, 34);
        issue_div(3'b111, 32'd100, 32'd7, 32'd2, 34);
        issue_div(3'b101, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1);
        issue_div(3'b110, 32'd5, 32'd0, 32'd5, 1);
        issue_div(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        issue_div(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        issue_div(3'b100, 32'd10, 32'd2, 32'd5, 34);
        drain();

        if (DIV_EN) flush_op(3'b100, 32'd1000, 32'd3, 10);
        else        flush_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        issue(3'b000, 32'd3, 32'd3, {1'b0, 32'd9}, 3, 1'b1);
        drain();
        flush_op(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 2);

        @(negedge clk);
        in_valid = 1'b1;
        flush    = 1'b1;
        in_op    = 3'b000;
        in_rs1   = 32'd4;
        in_rs2   = 32'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        check("flush_cancels_accept", {63'd0, in_ready}, 64'd1);
        repeat (6) @(negedge clk);

        issue(3'b000, 32'd3, 32'd3, {1'b0, 32'd9}, 3, 1'b1);
        drain();
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midop_reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("midop_reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("midop_reset_out_result", 64'(out_result), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);

        rand_bp = 1'b1;
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            issue(op, a, b, model(op, a, b), latency(op, a, b), 1'b1);
        end
        drain();
        rand_bp = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
